// File: rtl/register_block_mp_pkg.sv
// -----------------------------------------------------------------------------
// register_block_mp_pkg
//   Shared definitions for the multi-port register block:
//     - default parameter values (8 lanes, 64 regs, 32-bit words, 16 warps,
//       2 read ports)
//     - clr_state_t: states of the per-warp clear sequencer
//     - idx_w(): index width for a given element count (never below 1)
// -----------------------------------------------------------------------------
package register_block_mp_pkg;

    localparam int unsigned DEF_NUM_LANES    = 8;
    localparam int unsigned DEF_NUM_REGS     = 64;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_NUM_WARPS    = 16;
    localparam int unsigned DEF_NUM_RD_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/register_lane_bank.sv
// -----------------------------------------------------------------------------
// register_lane_bank
//   Storage for one SIMD lane: NUM_WARPS x NUM_REGS words, one external write
//   port, one clear write port (writes zero) and NUM_RD_PORTS registered read
//   ports with write-first bypass from both write ports.
//   Optional even parity per word when REG_PARITY_EN is defined.
//
// Ports
//   clk, rst_n     clock, async active-low reset (read registers only)
//   wr_en_i        external write enable for this lane
//   wr_warp_i      external write warp
//   wr_addr_i      external write register address
//   wr_data_i      external write data
//   clr_en_i       clear write enable (writes zero)
//   clr_warp_i     clear warp
//   clr_addr_i     clear register address
//   rd_en_i        per-port read enable for this lane
//   rd_warp_i      per-port read warp, packed
//   rd_addr_i      per-port read address, packed
//   rd_data_o      per-port registered read data, packed
//   rd_perr_o      per-port registered parity mismatch (0 without parity)
// -----------------------------------------------------------------------------
module register_lane_bank
    import register_block_mp_pkg::*;
#(
    parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned NUM_WARPS    = DEF_NUM_WARPS,
    parameter int unsigned NUM_RD_PORTS = DEF_NUM_RD_PORTS
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         wr_en_i,
    input  logic [idx_w(NUM_WARPS)-1:0]                  wr_warp_i,
    input  logic [idx_w(NUM_REGS)-1:0]                   wr_addr_i,
    input  logic [DATA_W-1:0]                            wr_data_i,
    input  logic                                         clr_en_i,
    input  logic [idx_w(NUM_WARPS)-1:0]                  clr_warp_i,
    input  logic [idx_w(NUM_REGS)-1:0]                   clr_addr_i,
    input  logic [NUM_RD_PORTS-1:0]                      rd_en_i,
    input  logic [NUM_RD_PORTS*idx_w(NUM_WARPS)-1:0]     rd_warp_i,
    input  logic [NUM_RD_PORTS*idx_w(NUM_REGS)-1:0]      rd_addr_i,
    output logic [NUM_RD_PORTS*DATA_W-1:0]               rd_data_o,
    output logic [NUM_RD_PORTS-1:0]                      rd_perr_o
);

    localparam int unsigned WW    = idx_w(NUM_WARPS);
    localparam int unsigned AW    = idx_w(NUM_REGS);
    localparam int unsigned DEPTH = NUM_WARPS * NUM_REGS;
    localparam int unsigned IW    = idx_w(DEPTH);
`ifdef REG_PARITY_EN
    localparam int unsigned MW    = DATA_W + 1;
`else
    localparam int unsigned MW    = DATA_W;
`endif

    // Stored word: data, plus even parity in the MSB when enabled.
    function automatic logic [MW-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef REG_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    function automatic logic [IW-1:0] flat_idx(input logic [WW-1:0] w,
                                               input logic [AW-1:0] a);
        return IW'(w) * IW'(NUM_REGS) + IW'(a);
    endfunction

    // Range checks use one extra bit so they stay meaningful when the
    // count is an exact power of two.
    function automatic logic in_range(input logic [WW-1:0] w,
                                      input logic [AW-1:0] a);
        return ({1'b0, w} < (WW+1)'(NUM_WARPS)) &&
               ({1'b0, a} < (AW+1)'(NUM_REGS));
    endfunction

    logic [MW-1:0]     mem_q [DEPTH];

    logic              wr_ok;
    logic              clr_ok;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     clr_idx;
    logic [IW-1:0]     rd_idx  [NUM_RD_PORTS];
    logic              rd_ok   [NUM_RD_PORTS];
    logic [MW-1:0]     rd_word [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] rd_mis;

    logic [DATA_W-1:0] rd_data_q [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] rd_perr_q;

    always_comb begin
        wr_ok   = in_range(wr_warp_i, wr_addr_i);
        clr_ok  = in_range(clr_warp_i, clr_addr_i);
        wr_idx  = flat_idx(wr_warp_i, wr_addr_i);
        clr_idx = flat_idx(clr_warp_i, clr_addr_i);
    end

    // Write-first read mux: the external write has priority over the clear
    // write, matching the storage update order below.
    always_comb begin
        rd_mis = '0;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            rd_ok[p]  = in_range(rd_warp_i[p*WW +: WW], rd_addr_i[p*AW +: AW]);
            rd_idx[p] = flat_idx(rd_warp_i[p*WW +: WW], rd_addr_i[p*AW +: AW]);
            if (!rd_ok[p]) begin
                rd_word[p] = '0;
            end else if (wr_en_i && wr_ok && (rd_idx[p] == wr_idx)) begin
                rd_word[p] = encode(wr_data_i);
            end else if (clr_en_i && clr_ok && (rd_idx[p] == clr_idx)) begin
                rd_word[p] = '0;
            end else begin
                rd_word[p] = mem_q[rd_idx[p]];
            end
`ifdef REG_PARITY_EN
            rd_mis[p] = ^rd_word[p];
`endif
        end
    end

    // Storage has no reset. Later assignment wins, so an external write to
    // the word being cleared keeps the external data.
    always_ff @(posedge clk) begin
        if (clr_en_i && clr_ok) begin
            mem_q[clr_idx] <= '0;
        end
        if (wr_en_i && wr_ok) begin
            mem_q[wr_idx] <= encode(wr_data_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
                rd_data_q[p] <= '0;
            end
            rd_perr_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
                if (rd_en_i[p]) begin
                    rd_data_q[p] <= rd_word[p][DATA_W-1:0];
                end
                rd_perr_q[p] <= rd_en_i[p] & rd_mis[p];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data_o[p*DATA_W +: DATA_W] = rd_data_q[p];
        end
    end

    assign rd_perr_o = rd_perr_q;

endmodule

// File: rtl/register_block_mp.sv
// -----------------------------------------------------------------------------
// register_block_mp
//   Per-lane register file indexed by (warp, register) with NUM_RD_PORTS
//   registered read ports, one lane-masked write port, write-first bypass and
//   a hardware sequencer that zeroes every register of one warp.
//   Define REG_PARITY_EN to store even parity per word and report mismatches
//   on par_err; otherwise par_err stays 0.
//
// Ports
//   clk, rst_n   clock, async active-low reset
//   rd_warp      warp select per read port (packed, WW bits each)
//   raddr        register address per read port (packed, AW bits each)
//   read_en      per-port per-lane read enable, bit p*NUM_LANES+l
//   rdata        read data, port p lane l at [(p*NUM_LANES+l)*DATA_W +: DATA_W]
//   rvalid       port p had any lane enabled in the previous cycle
//   wr_warp      write warp
//   waddr        write register address
//   write_en     per-lane write enable
//   wdata        per-lane write data
//   clr_req      start zeroing warp clr_warp (ignored while busy/done)
//   clr_warp     warp to clear
//   clr_busy     clear sequence running
//   clr_done     one-cycle pulse after the last register is cleared
//   par_err      registered parity error per read port
// -----------------------------------------------------------------------------
module register_block_mp
    import register_block_mp_pkg::*;
#(
    parameter int unsigned NUM_LANES    = DEF_NUM_LANES,
    parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned NUM_WARPS    = DEF_NUM_WARPS,
    parameter int unsigned NUM_RD_PORTS = DEF_NUM_RD_PORTS
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_RD_PORTS*idx_w(NUM_WARPS)-1:0]     rd_warp,
    input  logic [NUM_RD_PORTS*idx_w(NUM_REGS)-1:0]      raddr,
    input  logic [NUM_RD_PORTS*NUM_LANES-1:0]            read_en,
    output logic [NUM_RD_PORTS*NUM_LANES*DATA_W-1:0]     rdata,
    output logic [NUM_RD_PORTS-1:0]                      rvalid,
    input  logic [idx_w(NUM_WARPS)-1:0]                  wr_warp,
    input  logic [idx_w(NUM_REGS)-1:0]                   waddr,
    input  logic [NUM_LANES-1:0]                         write_en,
    input  logic [NUM_LANES*DATA_W-1:0]                  wdata,
    input  logic                                         clr_req,
    input  logic [idx_w(NUM_WARPS)-1:0]                  clr_warp,
    output logic                                         clr_busy,
    output logic                                         clr_done,
    output logic [NUM_RD_PORTS-1:0]                      par_err
);

    localparam int unsigned WW = idx_w(NUM_WARPS);
    localparam int unsigned AW = idx_w(NUM_REGS);

    clr_state_t    state_q, state_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic [WW-1:0] cwarp_q, cwarp_d;
    logic          clr_wr;

    logic [NUM_RD_PORTS-1:0]        rvalid_q;
    logic [NUM_RD_PORTS-1:0]        lane_re   [NUM_LANES];
    logic [NUM_RD_PORTS*DATA_W-1:0] lane_rd   [NUM_LANES];
    logic [NUM_RD_PORTS-1:0]        lane_perr [NUM_LANES];

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cwarp_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cwarp_q <= cwarp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cwarp_d  = cwarp_q;
        clr_wr   = 1'b0;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cwarp_d = clr_warp;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                clr_wr   = 1'b1;
                if (cnt_q == AW'(NUM_REGS - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- read valid ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
                rvalid_q[p] <= |read_en[p*NUM_LANES +: NUM_LANES];
            end
        end
    end

    assign rvalid = rvalid_q;

    // read_en is port-major; each bank wants its own lane's bit per port.
    always_comb begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
                lane_re[l][p] = read_en[p*NUM_LANES + l];
            end
        end
    end

    // ---------------- lane banks ----------------
    // The clear write is broadcast to every lane; each bank resolves it
    // against the external write (external wins on the same word).
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        register_lane_bank #(
            .NUM_REGS     (NUM_REGS),
            .DATA_W       (DATA_W),
            .NUM_WARPS    (NUM_WARPS),
            .NUM_RD_PORTS (NUM_RD_PORTS)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en_i    (write_en[l]),
            .wr_warp_i  (wr_warp),
            .wr_addr_i  (waddr),
            .wr_data_i  (wdata[l*DATA_W +: DATA_W]),
            .clr_en_i   (clr_wr),
            .clr_warp_i (cwarp_q),
            .clr_addr_i (cnt_q),
            .rd_en_i    (lane_re[l]),
            .rd_warp_i  (rd_warp),
            .rd_addr_i  (raddr),
            .rd_data_o  (lane_rd[l]),
            .rd_perr_o  (lane_perr[l])
        );
    end

    always_comb begin
        rdata   = '0;
        par_err = '0;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                rdata[(p*NUM_LANES + l)*DATA_W +: DATA_W] = lane_rd[l][p*DATA_W +: DATA_W];
                par_err[p] = par_err[p] | lane_perr[l][p];
            end
        end
    end

endmodule

// File: tb/tb_register_block_mp.sv
module tb_register_block_mp;

    localparam int L   = 8;
    localparam int R   = 64;
    localparam int DW  = 32;
    localparam int NW  = 16;
    localparam int NP  = 2;
    localparam int AW  = 6;
    localparam int WW  = 4;
    localparam int RDW = NP*L*DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP*WW-1:0]  rd_warp;
    logic [NP*AW-1:0]  raddr;
    logic [NP*L-1:0]   read_en;
    logic [RDW-1:0]    rdata;
    logic [NP-1:0]     rvalid;
    logic [WW-1:0]     wr_warp;
    logic [AW-1:0]     waddr;
    logic [L-1:0]      write_en;
    logic [L*DW-1:0]   wdata;
    logic              clr_req;
    logic [WW-1:0]     clr_warp;
    logic              clr_busy;
    logic              clr_done;
    logic [NP-1:0]     par_err;

    always #5 clk = ~clk;

    register_block_mp #(
        .NUM_LANES    (L),
        .NUM_REGS     (R),
        .DATA_W       (DW),
        .NUM_WARPS    (NW),
        .NUM_RD_PORTS (NP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_warp  (rd_warp),
        .raddr    (raddr),
        .read_en  (read_en),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .wr_warp  (wr_warp),
        .waddr    (waddr),
        .write_en (write_en),
        .wdata    (wdata),
        .clr_req  (clr_req),
        .clr_warp (clr_warp),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .par_err  (par_err)
    );

    // Reference model: plain per-lane arrays plus a clear start time.
    logic [DW-1:0] m   [L][NW][R];
    bit            bad [L][NW][R];
    logic [DW-1:0] exp_rd [NP][L];
    logic [NP-1:0] exp_rv;
    logic [NP-1:0] exp_pe;
    bit            exp_busy;
    bit            exp_done;
    int            cyc;
    int            clr_s;
    int            clr_w;
    int            tests;
    int            fails;

    task automatic chk(input string tag, input logic [RDW-1:0] obs, input logic [RDW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [RDW-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++)
            for (int l = 0; l < L; l++)
                v[(p*L+l)*DW +: DW] = exp_rd[p][l];
        chk("rdata", rdata, v);
        chk("rvalid", RDW'(rvalid), RDW'(exp_rv));
        chk("clr_busy", RDW'(clr_busy), RDW'(exp_busy));
        chk("clr_done", RDW'(clr_done), RDW'(exp_done));
        chk("par_err", RDW'(par_err), RDW'(exp_pe));
    endtask

    task automatic idle_inputs();
        rd_warp  = '0;
        raddr    = '0;
        read_en  = '0;
        wr_warp  = '0;
        waddr    = '0;
        write_en = '0;
        wdata    = '0;
        clr_req  = 1'b0;
        clr_warp = '0;
    endtask

    // Predict the effect of the coming edge, advance one clock, check.
    // A clear accepted at edge s zeroes reg k at edge s+1+k; busy follows
    // edges s..s+63, done follows edge s+64.
    task automatic tick();
        int e, pre, d, ck, w, a;
        bit cw, b;
        logic [DW-1:0] v;
        logic [NP-1:0] pe;
        e   = cyc + 1;
        pre = cyc - clr_s;
        d   = e - clr_s;
        cw  = (d >= 1 && d <= R);
        ck  = d - 1;
        pe  = '0;
        for (int p = 0; p < NP; p++) begin
            exp_rv[p] = |read_en[p*L +: L];
            w = int'(rd_warp[p*WW +: WW]);
            a = int'(raddr[p*AW +: AW]);
            for (int l = 0; l < L; l++) begin
                if (read_en[p*L+l]) begin
                    if (write_en[l] && int'(wr_warp) == w && int'(waddr) == a) begin
                        v = wdata[l*DW +: DW]; b = 0;
                    end else if (cw && clr_w == w && ck == a) begin
                        v = '0; b = 0;
                    end else begin
                        v = m[l][w][a]; b = bad[l][w][a];
                    end
                    exp_rd[p][l] = v;
                    if (b) pe[p] = 1'b1;
                end
            end
        end
        exp_pe = pe;
        if (cw)
            for (int l = 0; l < L; l++) begin
                m[l][clr_w][ck] = '0; bad[l][clr_w][ck] = 0;
            end
        for (int l = 0; l < L; l++)
            if (write_en[l]) begin
                m[l][wr_warp][waddr] = wdata[l*DW +: DW]; bad[l][wr_warp][waddr] = 0;
            end
        if (clr_req && !(pre >= 0 && pre <= R)) begin
            clr_s = e;
            clr_w = int'(clr_warp);
        end
        d = e - clr_s;
        exp_busy = (d >= 0 && d <= R-1);
        exp_done = (d == R);
        @(posedge clk);
        cyc = e;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        for (int p = 0; p < NP; p++)
            for (int l = 0; l < L; l++)
                exp_rd[p][l] = '0;
        exp_rv = '0; exp_pe = '0; exp_busy = 0; exp_done = 0;
        clr_s = -1000;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr_all(input int w, input int a, input logic [DW-1:0] v);
        write_en = '1;
        wr_warp  = WW'(w);
        waddr    = AW'(a);
        wdata    = {L{v}};
        tick();
        write_en = '0;
    endtask

    task automatic set_rd(input int p, input int w, input int a, input logic [L-1:0] en);
        rd_warp[p*WW +: WW] = WW'(w);
        raddr[p*AW +: AW]   = AW'(a);
        read_en[p*L +: L]   = en;
    endtask

    task automatic fill_warp(input int w, output logic [DW-1:0] lane0 [R]);
        for (int a = 0; a < R; a++) begin
            write_en = '1;
            wr_warp  = WW'(w);
            waddr    = AW'(a);
            for (int l = 0; l < L; l++) wdata[l*DW +: DW] = $urandom;
            lane0[a] = wdata[DW-1:0];
            tick();
        end
        write_en = '0;
    endtask

    logic [DW-1:0] f9 [R];
    logic [DW-1:0] f8 [R];
    int nb;
    bit hot;

    initial begin
        tests = 0; fails = 0; cyc = 0; clr_s = -1000; clr_w = 0;
        for (int l = 0; l < L; l++)
            for (int w = 0; w < NW; w++)
                for (int a = 0; a < R; a++) begin
                    m[l][w][a] = '0; bad[l][w][a] = 0;
                end
        do_reset();

        // Zero all storage with the clear sequencer.
        for (int w = 0; w < NW; w++) begin
            clr_req = 1'b1; clr_warp = WW'(w);
            tick();
            clr_req = 1'b0;
            repeat (R+1) tick();
        end

        // Write then read one cycle later.
        wr_all(3, 5, 32'hDEADBEEF);
        set_rd(0, 3, 5, '1);
        tick();
        read_en = '0;
        for (int l = 0; l < L; l++) chk("t1_data", RDW'(rdata[l*DW +: DW]), RDW'(32'hDEADBEEF));
        chk("t1_rvalid0", RDW'(rvalid[0]), RDW'(1'b1));
        chk("t1_rvalid1", RDW'(rvalid[1]), RDW'(1'b0));

        // Same-cycle write and read on both ports (bypass).
        write_en = 8'h04; wr_warp = 4'd7; waddr = 6'd63;
        wdata[2*DW +: DW] = 32'h12345678;
        set_rd(0, 7, 63, 8'h04);
        set_rd(1, 7, 63, 8'h04);
        tick();
        write_en = '0; read_en = '0;
        chk("t2_p0", RDW'(rdata[(0*L+2)*DW +: DW]), RDW'(32'h12345678));
        chk("t2_p1", RDW'(rdata[(1*L+2)*DW +: DW]), RDW'(32'h12345678));

        // Partial lane mask over cleared word.
        write_en = 8'h0F; wr_warp = 4'd2; waddr = 6'd10; wdata = {L{32'hA5A5A5A5}};
        tick();
        write_en = '0;
        set_rd(1, 2, 10, '1);
        tick();
        read_en = '0;
        for (int l = 0; l < L; l++)
            chk("t3_mask", RDW'(rdata[(L+l)*DW +: DW]), RDW'((l < 4) ? 32'hA5A5A5A5 : 32'h0));

        // Fill warps 9 and 8, clear warp 9; clr_req during clear is ignored.
        fill_warp(9, f9);
        fill_warp(8, f8);
        clr_req = 1'b1; clr_warp = 4'd9;
        tick();
        clr_warp = 4'd4;
        nb = clr_busy ? 1 : 0;
        for (int i = 0; i < 200 && clr_busy; i++) begin
            tick();
            if (clr_busy) nb++;
        end
        chk("t4_busy_len", RDW'(nb), RDW'(R));
        chk("t4_done", RDW'(clr_done), RDW'(1'b1));
        tick();
        clr_req = 1'b0;
        chk("t4_done_pulse", RDW'(clr_done), RDW'(1'b0));
        chk("t4_no_restart", RDW'(clr_busy), RDW'(1'b0));
        for (int a = 0; a < R; a++) begin
            set_rd(0, 9, a, '1);
            set_rd(1, 8, a, '1);
            tick();
            chk("t4_w9_zero", RDW'(rdata[L*DW-1:0]), '0);
            chk("t4_w8_keep", RDW'(rdata[L*DW +: DW]), RDW'(f8[a]));
        end
        read_en = '0;

        // Reset in the middle of a clear.
        fill_warp(9, f9);
        clr_req = 1'b1; clr_warp = 4'd9;
        set_rd(1, 8, 1, '1);
        tick();
        clr_req = 1'b0;
        repeat (20) tick();
        do_reset();
        chk("t5_busy", RDW'(clr_busy), RDW'(1'b0));
        chk("t5_rdata", rdata, '0);
        for (int a = 0; a < R; a++) begin
            set_rd(0, 9, a, 8'h01);
            tick();
            chk("t5_reg", RDW'(rdata[DW-1:0]), RDW'((a < 20) ? 32'h0 : f9[a]));
        end
        read_en = '0;
        tick();
        chk("t5_idle", RDW'(clr_busy), RDW'(1'b0));

`ifdef REG_PARITY_EN
        wr_all(1, 1, 32'h0F0F0F0F);
        dut.g_lane[0].u_bank.mem_q[1*R+1][0] = ~dut.g_lane[0].u_bank.mem_q[1*R+1][0];
        m[0][1][1][0] = ~m[0][1][1][0];
        bad[0][1][1] = 1;
        set_rd(0, 1, 1, 8'h01);
        tick();
        read_en = '0;
        chk("t6_par_err", RDW'(par_err[0]), RDW'(1'b1));
        wr_all(1, 1, 32'h0);
`endif

        // Randomized traffic with collisions and occasional clears.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++) begin
                hot = ($urandom_range(0, 1) == 1);
                rd_warp[p*WW +: WW] = hot ? WW'(5) : WW'($urandom_range(0, NW-1));
                raddr[p*AW +: AW]   = hot ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, R-1));
            end
            read_en  = (NP*L)'($urandom);
            write_en = L'($urandom);
            hot      = ($urandom_range(0, 1) == 1);
            wr_warp  = hot ? WW'(5) : WW'($urandom_range(0, NW-1));
            waddr    = hot ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, R-1));
            for (int l = 0; l < L; l++) wdata[l*DW +: DW] = $urandom;
            clr_req  = ($urandom_range(0, 63) == 0);
            clr_warp = hot ? WW'(5) : WW'($urandom_range(0, NW-1));
            tick();
        end
        idle_inputs();
        repeat (R+2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion before 2000000");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/register_block_mp.md
Name: register_block_mp

Overview:
- Parametrised successor to the fixed 8-lane/64-reg/32-bit/16-warp register block.
- Per-lane register storage indexed by (warp, register), with N read ports and one per-lane-masked write port.
- Adds registered reads, independent read and write warp selects, write-first bypass, and a hardware per-warp clear sequencer.
- Sits between the warp scheduler/decode stage (reads) and writeback (writes) in each core.

Parameters:
NUM_LANES, 8, SIMD lanes (independent storage per lane)
NUM_REGS, 64, registers per warp per lane; AW = $clog2(NUM_REGS)
DATA_W, 32, register word width
NUM_WARPS, 16, warps; WW = $clog2(NUM_WARPS)
NUM_RD_PORTS, 2, read ports

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
rd_warp  in  NUM_RD_PORTS*WW  warp select per read port
raddr  in  NUM_RD_PORTS*AW  register address per read port
read_en  in  NUM_RD_PORTS*NUM_LANES  per-port, per-lane read enable
rdata  out  NUM_RD_PORTS*NUM_LANES*DATA_W  read data; port p, lane l at slice [(p*NUM_LANES+l)*DATA_W +: DATA_W]
rvalid  out  NUM_RD_PORTS  port had any lane enabled in the previous cycle
wr_warp  in  WW  write warp
waddr  in  AW  write address
write_en  in  NUM_LANES  per-lane write enable
wdata  in  NUM_LANES*DATA_W  per-lane write data
clr_req  in  1  request zeroing of warp clr_warp
clr_warp  in  WW  warp to clear
clr_busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse when clear completes
par_err  out  NUM_RD_PORTS  parity error on registered read (see Optional Feature)

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous, active-low.
  - Outputs on reset: rdata=0, rvalid=0, clr_busy=0, clr_done=0, par_err=0, FSM=IDLE, clear counter=0.
  - Storage is not reset; contents are undefined until written or cleared.
- Write: at posedge, each lane l with write_en[l]=1 stores its wdata slice at (wr_warp, waddr). Lanes not enabled are unchanged.
- Read: registered, 1-cycle latency.
  - At posedge, for each port p and lane l with read_en[p][l]=1, rdata[p][l] <= mem_l[rd_warp[p]][raddr[p]].
  - Disabled lanes hold their previous rdata.
  - rvalid[p] <= |read_en[p].
- Bypass (write-first): if read and write in the same cycle hit the same warp, address and lane, rdata returns the new wdata.
- Multiple ports reading the same location in the same cycle each receive identical data.
- Out-of-range warp (index >= NUM_WARPS) or address (>= NUM_REGS): writes are dropped; reads load 0.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR; latch clr_warp; cnt=0.
  - CLEAR: clr_busy=1. Each cycle, write 0 to (latched warp, cnt) in all lanes; cnt++. When cnt==NUM_REGS-1, go to DONE after that write.
  - DONE: clr_done=1 for exactly one cycle, then IDLE.
  - Clear takes NUM_REGS cycles plus 1 for DONE.
- clr_req while in CLEAR or DONE is ignored; no queueing.
- External write colliding with the clear write (same warp, same cnt, same lane): external write wins.
- Reads are never stalled during a clear; they return current storage contents, with bypass applying to clear writes too.
- rst_n assertion mid-clear: FSM returns to IDLE immediately and clr_busy drops. The warp is left partially cleared; software must re-request the clear.

Optional Feature:
- Macro: REG_PARITY_EN.
- Defined:
  - Each lane word stores an extra even-parity bit computed on write; clear writes parity 0.
  - On registered read, par_err[p] <= OR over enabled lanes of the parity mismatch.
  - Bypassed reads use freshly computed parity.
- Undefined: no parity storage; par_err is tied to 0. The port is always present.

Decomposition:
- Package register_block_mp_pkg:
  - default parameter constants;
  - clr_state_t enum {IDLE, CLEAR, DONE};
  - width helper functions (AW/WW derivation).
- Sub-module register_lane_bank: one lane's NUM_WARPS*NUM_REGS storage with NUM_RD_PORTS registered read ports, bypass, and optional parity. Instantiated NUM_LANES times by generate.
- Top level holds the clear FSM, the write/clear mux, and rvalid.

Test Plan:
- Write 0xDEADBEEF to warp 3, reg 5, all lanes. Next cycle read port 0 -> one cycle later rdata lanes 0..7 = 0xDEADBEEF, rvalid[0]=1.
- Same-cycle write 0x12345678 and read on both ports at warp 7, reg 63, lane 2 -> both ports' lane 2 = 0x12345678 next cycle.
- write_en=8'h0F with data 0xA5A5A5A5 over prior 0 -> lanes 0-3 read 0xA5A5A5A5, lanes 4-7 read 0.
- Fill warp 9, then pulse clr_req with clr_warp=9:
  - clr_busy high for 64 cycles, then clr_done for 1 cycle;
  - all regs of warp 9 read 0;
  - warp 8 is unchanged.
- Assert rst_n low at clear cycle 20 -> clr_busy=0 and rdata=0 immediately; regs 0-19 read 0, reg 40 keeps its old value.
- With REG_PARITY_EN, force-flip one stored bit at warp 1, reg 1 -> read gives par_err[0]=1 one cycle after the read.
